// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port word memory (1-cycle registered read,
// byte-masked write). One transaction per IDLE/RESP -> ISSUE -> RESP sequence.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [3:0]        p0_wmask,
  input  logic              p0_rstrb,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [3:0]        p1_wmask,
  input  logic              p1_rstrb,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_rstrb,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e            state_q;
  // Last winner; doubles as the owner of the in-flight transaction. Resets to 1
  // so port 0 wins the first tie.
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              mem_rstrb_q;
  logic [3:0]        mem_wmask_q;
  logic [1:0]        gnt_q;
  logic [1:0]        rvalid_q;

  logic              any_req;
  logic              win;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_wmask;
  logic              sel_rstrb;

  always_comb begin
    any_req = p0_req | p1_req;
    win     = 1'b0;
    if (p0_req && p1_req) begin
      win = RR_EN ? ~last_q : 1'b0;
    end else if (p1_req) begin
      win = 1'b1;
    end
  end

  assign sel_addr  = win ? p1_addr  : p0_addr;
  assign sel_wdata = win ? p1_wdata : p0_wdata;
  assign sel_wmask = win ? p1_wmask : p0_wmask;
  assign sel_rstrb = win ? p1_rstrb : p0_rstrb;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_rstrb_q <= 1'b0;
      mem_wmask_q <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
    end else begin
      case (state_q)
        StIdle, StResp: begin
          rvalid_q <= '0;
          if (any_req) begin
            state_q     <= StIssue;
            last_q      <= win;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            mem_rstrb_q <= sel_rstrb;
            mem_wmask_q <= sel_wmask;
            gnt_q       <= win ? 2'b10 : 2'b01;
          end else begin
            state_q <= StIdle;
          end
        end
        StIssue: begin
          // Strobes live for exactly the ISSUE cycle; completion follows next cycle.
          gnt_q       <= '0;
          mem_rstrb_q <= 1'b0;
          mem_wmask_q <= '0;
          rvalid_q    <= last_q ? 2'b10 : 2'b01;
          state_q     <= StResp;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign p0_gnt    = gnt_q[0];
  assign p1_gnt    = gnt_q[1];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign rdata     = mem_rdata;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rstrb = mem_rstrb_q;
  assign mem_wmask = mem_wmask_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed cases plus randomized rounds,
// expected grants/read data predicted from a word-array memory model.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam bit RR = 1'b1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          p0_req = 1'b0, p1_req = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [31:0]   p0_wdata = '0, p1_wdata = '0;
  logic [3:0]    p0_wmask = '0, p1_wmask = '0;
  logic          p0_rstrb = 1'b0, p1_rstrb = 1'b0;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0]   rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          mem_rstrb;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic          busy;

  // Fixed-priority instance shares the requester inputs; only its grants are checked.
  logic          fp_p0_gnt, fp_p1_gnt, fp_p0_rvalid, fp_p1_rvalid, fp_mem_rstrb, fp_busy;
  logic [31:0]   fp_rdata, fp_mem_wdata;
  logic [AW-1:0] fp_mem_addr;
  logic [3:0]    fp_mem_wmask;
  logic [31:0]   fp_mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(AW), .RR_EN(RR)) dut (
    .clk(clk), .resetn(resetn),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_rstrb(p0_rstrb), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_rstrb(p1_rstrb), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rstrb(mem_rstrb),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .resetn(resetn),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_rstrb(p0_rstrb), .p0_gnt(fp_p0_gnt), .p0_rvalid(fp_p0_rvalid),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_rstrb(p1_rstrb), .p1_gnt(fp_p1_gnt), .p1_rvalid(fp_p1_rvalid),
    .rdata(fp_rdata), .mem_addr(fp_mem_addr), .mem_rdata(fp_mem_rdata),
    .mem_rstrb(fp_mem_rstrb), .mem_wdata(fp_mem_wdata), .mem_wmask(fp_mem_wmask),
    .busy(fp_busy)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 100) return 32'h0403_0201;
    if (i == 200) return 32'h1122_3344;
    if (i == 4) return 32'h0;
    return (i * 32'h0100_0193) ^ 32'h5a5a_a5a5;
  endfunction

  // Memory: read captures the pre-write word, then the masked write lands.
  logic [31:0] mem [256];
  initial begin
    logic [31:0] rd;
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      rd = mem_rdata;
      if (mem_rstrb) rd = mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      mem_rdata = rd;
    end
  end

  typedef struct {
    bit          port;
    bit          chk;
    logic [31:0] data;
  } rv_t;

  rv_t         exp_rv[$];
  bit          exp_gnt[$];
  logic [31:0] ref_mem [256];
  bit          rr_last = 1'b1;
  int          checks = 0;
  int          failures = 0;
  int          wmask_cycles = 0;
  int          strobe_cycles = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] pick(bit p, logic a0, logic a1);
    return {31'b0, p ? a1 : a0};
  endfunction

  // Transactions are predicted in service order; reads see the pre-write word.
  function automatic logic [31:0] expect_txn(bit port, logic [31:0] addr, logic [31:0] wdata,
                                              logic [3:0] wmask, bit rstrb);
    int          idx = int'(addr[9:2]);
    logic [31:0] old = ref_mem[idx];
    rv_t         it;
    for (int b = 0; b < 4; b++)
      if (wmask[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    it.port = port;
    it.chk  = rstrb;
    it.data = old;
    exp_rv.push_back(it);
    exp_gnt.push_back(port);
    return old;
  endfunction

  initial begin
    bit  g;
    rv_t it;
    forever begin
      @(negedge clk);
      if (mem_wmask != 4'h0) wmask_cycles++;
      if (mem_rstrb || mem_wmask != 4'h0) strobe_cycles++;
      if (p0_gnt || p1_gnt) begin
        if (exp_gnt.size() == 0) begin
          check("gnt_unexpected", 32'({p1_gnt, p0_gnt}), 32'h0);
        end else begin
          g = exp_gnt.pop_front();
          check("gnt_port", 32'({p1_gnt, p0_gnt}), g ? 32'h2 : 32'h1);
        end
      end
      if (p0_rvalid || p1_rvalid) begin
        if (exp_rv.size() == 0) begin
          check("rvalid_unexpected", 32'({p1_rvalid, p0_rvalid}), 32'h0);
        end else begin
          it = exp_rv.pop_front();
          check("rvalid_port", 32'({p1_rvalid, p0_rvalid}), it.port ? 32'h2 : 32'h1);
          if (it.chk) check("rdata", rdata, it.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input int p, input bit req, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input bit r);
    if (p == 0) begin
      p0_req = req; p0_addr = a; p0_wdata = d; p0_wmask = m; p0_rstrb = r;
    end else begin
      p1_req = req; p1_addr = a; p1_wdata = d; p1_wmask = m; p1_rstrb = r;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) p0_req = 1'b0;
    else p1_req = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    rr_last = 1'b1;
  endtask

  // Single requester from IDLE/RESP; returns #1 into RESP with rvalid high.
  task automatic run_single(input bit p, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m, input bit r);
    logic [31:0] e;
    e = expect_txn(p, a, d, m, r);
    rr_last = p;
    drive(int'(p), 1'b1, a, d, m, r);
    @(posedge clk); #1;
    check("gnt_latency", pick(p, p0_gnt, p1_gnt), 32'h1);
    check("gnt_other", pick(p, p1_gnt, p0_gnt), 32'h0);
    drop(int'(p));
    @(posedge clk); #1;
    check("rvalid_latency", pick(p, p0_rvalid, p1_rvalid), 32'h1);
    check("rvalid_other", pick(p, p1_rvalid, p0_rvalid), 32'h0);
    if (r) check("rdata_latency", rdata, e);
  endtask

  initial begin
    int w0, s0, n, lastc, fp0, fp1, gap;
    logic [1:0]  pm, done;
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [3:0]  m [2];
    bit          rs [2];
    bit          first;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_gnt", 32'({p1_gnt, p0_gnt}), 32'h0);
    check("rst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'h0);
    check("rst_strobes", 32'({mem_rstrb, mem_wmask}), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    run_single(1'b0, 32'h190, 32'h0, 4'h0, 1'b1);
    check("t1_rdata", rdata, 32'h0403_0201);

    w0 = wmask_cycles;
    run_single(1'b1, 32'h320, 32'h0000_00AA, 4'b0001, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("t2_wmask_cycles", 32'(wmask_cycles - w0), 32'h1);
    run_single(1'b1, 32'h320, 32'h0, 4'h0, 1'b1);
    check("t2_rdata", rdata, 32'h1122_33AA);

    run_single(1'b0, 32'h10, 32'h1234_5678, 4'hF, 1'b1);
    check("t4_prewrite", rdata, 32'h0);
    run_single(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    check("t4_readback", rdata, 32'h1234_5678);

    s0 = strobe_cycles;
    run_single(1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("t6_strobe_cycles", 32'(strobe_cycles - s0), 32'h0);

    for (int r = 0; r < 40; r++) begin
      pm = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        a[p]  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        d[p]  = $urandom;
        m[p]  = 4'($urandom_range(0, 15));
        rs[p] = 1'($urandom_range(0, 1));
      end
      if (pm == 2'b11) begin
        first = RR ? ~rr_last : 1'b0;
        void'(expect_txn(first, a[first], d[first], m[first], rs[first]));
        void'(expect_txn(~first, a[~first], d[~first], m[~first], rs[~first]));
        rr_last = ~first;
      end else begin
        first = (pm == 2'b10);
        void'(expect_txn(first, a[first], d[first], m[first], rs[first]));
        rr_last = first;
      end
      for (int p = 0; p < 2; p++)
        if (pm[p]) drive(p, 1'b1, a[p], d[p], m[p], rs[p]);
      done = 2'b00;
      for (int c = 0; c < 16 && done != pm; c++) begin
        @(posedge clk); #1;
        if (pm[0] && !done[0] && p0_gnt) begin done[0] = 1'b1; drop(0); end
        if (pm[1] && !done[1] && p1_gnt) begin done[1] = 1'b1; drop(1); end
      end
      check("round_done", 32'(done), 32'(pm));
      drop(0);
      drop(1);
      n = $urandom_range(0, 2);
      repeat (n) @(posedge clk);
      if (n != 0) #1;
    end
    repeat (3) @(posedge clk); #1;

    do_reset();
    for (int k = 0; k < 6; k++) void'(expect_txn(k[0], k[0] ? 32'h320 : 32'h190, 32'h0, 4'h0, 1'b1));
    rr_last = 1'b1;
    drive(0, 1'b1, 32'h190, 32'h0, 4'h0, 1'b1);
    drive(1, 1'b1, 32'h320, 32'h0, 4'h0, 1'b1);
    n = 0; lastc = 0; fp0 = 0; fp1 = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      fp0 += int'(fp_p0_gnt);
      fp1 += int'(fp_p1_gnt);
      if (n < 6 && (p0_gnt || p1_gnt)) begin
        if (n > 0) begin
          gap = c - lastc;
          check("t3_gnt_gap", 32'(gap), 32'h2);
        end
        lastc = c;
        n++;
        if (n == 6) begin drop(0); drop(1); end
      end
    end
    check("t3_rr_count", 32'(n), 32'h6);
    check("t3_fp_p0", 32'(fp0), 32'h6);
    check("t3_fp_p1", 32'(fp1), 32'h0);

    drive(0, 1'b1, 32'h190, 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    check("t5_issue_rstrb", 32'(mem_rstrb), 32'h1);
    check("t5_issue_busy", 32'(busy), 32'h1);
    resetn = 1'b0;
    drop(0);
    #1;
    check("t5_rstrb_drop", 32'(mem_rstrb), 32'h0);
    check("t5_busy_drop", 32'(busy), 32'h0);
    check("t5_gnt_drop", 32'(p0_gnt), 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    rr_last = 1'b1;
    run_single(1'b0, 32'h190, 32'h0, 4'h0, 1'b1);

    repeat (3) @(posedge clk); #1;
    check("queues_empty", 32'(exp_rv.size() + exp_gnt.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
